bpsk_bit_framer: RTL and testbench

- Upstream stage of bpsk_modulator_top.
- Accepts payload bytes over a valid/ready stream and prepends a fixed preamble.
- Serializes the frame MSB-first and holds each bit for SAMPLES_PER_SYMBOL clocks.
- Drives the modulator's bit input and enable, so a frame goes out as a continuous symbol stream at the 200 MHz sample clock.

---
 rtl/bpsk_bit_framer.sv | 193 +++++++++++++++++++
 tb/tb_bpsk_bit_framer.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpsk_bit_framer.sv
// rtl/bpsk_bit_framer.sv - preamble + MSB-first payload serializer feeding the BPSK modulator
//
// Ports:
//   clk          sample clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   s_data       payload byte
//   s_valid      s_data / s_last valid
//   s_last       final byte of the frame
//   s_ready      registered; block can accept a byte this cycle
//   bit_out      serial bit to the modulator input
//   mod_en       modulator enable, high for the whole frame
//   sym_strobe   one-cycle pulse on the first clock of every symbol
//   frame_active high while sending preamble or payload
//   underrun     one-cycle pulse when a frame is abandoned for lack of data
module bpsk_bit_framer #(
    parameter int                      SAMPLES_PER_SYMBOL = 20,
    parameter int                      PREAMBLE_LEN       = 16,
    parameter logic [PREAMBLE_LEN-1:0] PREAMBLE           = 16'hAAAA
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       bit_out,
    output logic       mod_en,
    output logic       sym_strobe,
    output logic       frame_active,
    output logic       underrun
);

    localparam int SCW = $clog2(SAMPLES_PER_SYMBOL);
    localparam int BIW = $clog2(PREAMBLE_LEN) + 1;
    localparam logic [SCW-1:0] SYM_LAST = SCW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [BIW-1:0] BI_TOP   = BIW'(PREAMBLE_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SCW-1:0]          sym_cnt;
    logic [BIW-1:0]          bit_idx;
    logic [2:0]              bit_cnt;
    logic [7:0]              shift_reg;
    logic [7:0]              hold_buf;
    logic                    hold_full;
    logic                    last_pending;
    logic                    ready_q;
    logic                    underrun_q;

    logic                    xfer;
    logic                    sym_end;
    logic                    pre_done;
    logic                    byte_end;
    logic                    load;
    logic                    frame_end;
    logic                    abort;
    logic [PREAMBLE_LEN-1:0] pre_shift;

    assign xfer      = s_valid & ready_q;
    assign sym_end   = (sym_cnt == SYM_LAST);
    assign pre_done  = (state == S_PREAMBLE) && sym_end && (bit_idx == '0);
    assign byte_end  = (state == S_PAYLOAD) && sym_end && (bit_cnt == 3'd0);
    // The hold buffer is always full during the preamble, so pre_done is a load.
    assign load      = pre_done | (byte_end & hold_full);
    assign frame_end = byte_end & ~hold_full;
    // Byte boundary with nothing queued and no s_last seen: abandon the frame.
    assign abort     = frame_end & ~last_pending;
    // Shift rather than index so the selector width never exceeds the pattern.
    assign pre_shift = PREAMBLE >> bit_idx;

    assign s_ready   = ready_q;
    assign underrun  = underrun_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                // hold_full covers a byte accepted on the same edge as an abort.
                if (xfer || hold_full) begin
                    state_next = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (pre_done) begin
                    state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (frame_end) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bit_out      = 1'b0;
        mod_en       = 1'b0;
        frame_active = 1'b0;
        sym_strobe   = 1'b0;
        case (state)
            S_PREAMBLE: begin
                bit_out      = pre_shift[0];
                mod_en       = 1'b1;
                frame_active = 1'b1;
                sym_strobe   = (sym_cnt == '0);
            end
            S_PAYLOAD: begin
                bit_out      = shift_reg[7];
                mod_en       = 1'b1;
                frame_active = 1'b1;
                sym_strobe   = (sym_cnt == '0);
            end
            default: ;
        endcase
    end

    // Counters, shift register, hold buffer and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt      <= '0;
            bit_idx      <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            hold_buf     <= '0;
            hold_full    <= 1'b0;
            last_pending <= 1'b0;
            ready_q      <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            if ((state == S_IDLE) || (state_next != state) || sym_end) begin
                sym_cnt <= '0;
            end else begin
                sym_cnt <= sym_cnt + SCW'(1);
            end

            if ((state == S_IDLE) && (state_next == S_PREAMBLE)) begin
                bit_idx <= BI_TOP;
            end else if ((state == S_PREAMBLE) && sym_end && (bit_idx != '0)) begin
                bit_idx <= bit_idx - BIW'(1);
            end

            if (load) begin
                bit_cnt   <= 3'd7;
                shift_reg <= hold_buf;
            end else if ((state == S_PAYLOAD) && sym_end) begin
                bit_cnt   <= bit_cnt - 3'd1;
                shift_reg <= {shift_reg[6:0], 1'b0};
            end

            if (xfer) begin
                hold_buf <= s_data;
            end

            // xfer and load never coincide: ready_q is low whenever hold_full is set.
            if (xfer) begin
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end

            if (xfer && s_last) begin
                last_pending <= 1'b1;
            end else if (frame_end) begin
                last_pending <= 1'b0;
            end

            // Built from the pre-edge flags, so a freed slot shows one edge later.
            ready_q    <= ~hold_full & ~last_pending & ~xfer;
            underrun_q <= abort;
        end
    end

endmodule

// File: tb/tb_bpsk_bit_framer.sv
// tb/tb_bpsk_bit_framer.sv - self-checking bench for bpsk_bit_framer
module tb_bpsk_bit_framer;

    localparam int          SPS   = 20;
    localparam int          PL    = 16;
    localparam logic [15:0] PRE   = 16'hAAAA;
    localparam int          SPS_B = 2;
    localparam int          PL_B  = 4;
    localparam logic [15:0] PRE_B = 16'h000D;
    localparam int F_UND = 0;
    localparam int F_RDY = 1;
    localparam int F_STB = 2;
    localparam int F_XF  = 3;

    typedef logic [7:0] byteq_t[$];
    typedef logic bitq_t[$];
    typedef struct packed {
        logic en;
        logic bo;
        logic stb;
        logic und;
        logic fa;
        logic rdy;
        logic xf;
    } smp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready, bit_out, mod_en, sym_strobe, frame_active, underrun;
    logic [7:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_last = 1'b0;
    logic       b_ready, b_bit, b_en, b_stb, b_fa, b_und;

    int   checks = 0;
    int   errors = 0;
    smp_t tr_a[$];
    smp_t tr_b[$];
    bit   cap = 1'b0;

    always #5 clk = ~clk;

    bpsk_bit_framer #(.SAMPLES_PER_SYMBOL(SPS), .PREAMBLE_LEN(PL), .PREAMBLE(PRE)) dut_a (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .bit_out(bit_out), .mod_en(mod_en), .sym_strobe(sym_strobe),
        .frame_active(frame_active), .underrun(underrun)
    );

    bpsk_bit_framer #(.SAMPLES_PER_SYMBOL(SPS_B), .PREAMBLE_LEN(PL_B), .PREAMBLE(4'b1101)) dut_b (
        .clk(clk), .rst(rst), .s_data(b_data), .s_valid(b_valid), .s_last(b_last),
        .s_ready(b_ready), .bit_out(b_bit), .mod_en(b_en), .sym_strobe(b_stb),
        .frame_active(b_fa), .underrun(b_und)
    );

    // Per-clock trace; xf marks that the following rising edge transfers a byte.
    always @(negedge clk) begin
        if (cap) begin
            tr_a.push_back({mod_en, bit_out, sym_strobe, underrun, frame_active, s_ready, s_valid & s_ready});
            tr_b.push_back({b_en, b_bit, b_stb, b_und, b_fa, b_ready, b_valid & b_ready});
        end
    end

    // Reference waveform: every frame bit repeated sps times, preamble then payload MSB first.
    function automatic bitq_t model_wave(byteq_t b, int sps, int pl, logic [15:0] pre);
        bitq_t w;
        for (int i = pl - 1; i >= 0; i--) repeat (sps) w.push_back(pre[i]);
        foreach (b[k]) for (int i = 7; i >= 0; i--) repeat (sps) w.push_back(b[k][i]);
        return w;
    endfunction

    function automatic int tr_size(bit sel);
        return sel ? tr_b.size() : tr_a.size();
    endfunction

    function automatic smp_t get(bit sel, int i);
        if (i < 0 || i >= tr_size(sel)) return '0;
        return sel ? tr_b[i] : tr_a[i];
    endfunction

    function automatic int run_start(bit sel, int k);
        int   n = 0;
        smp_t s, p;
        for (int i = 0; i < tr_size(sel); i++) begin
            s = get(sel, i);
            p = get(sel, i - 1);
            if (s.en && !p.en) begin
                if (n == k) return i;
                n++;
            end
        end
        return -1;
    endfunction

    function automatic int run_len(bit sel, int st);
        int   n = 0;
        smp_t s;
        if (st < 0) return 0;
        for (int i = st; i < tr_size(sel); i++) begin
            s = get(sel, i);
            if (!s.en) break;
            n++;
        end
        return n;
    endfunction

    function automatic int wave_errs(bit sel, int st, bitq_t w, int sps);
        int   e = 0;
        smp_t s;
        if (st < 0) return w.size();
        foreach (w[i]) begin
            s = get(sel, st + i);
            if (s.bo !== w[i] || s.stb !== (i % sps == 0) || s.fa !== 1'b1 || s.en !== 1'b1) e++;
        end
        return e;
    endfunction

    function automatic int count_f(bit sel, int from, int n, int f);
        int   c = 0;
        smp_t s;
        for (int i = from; i < from + n; i++) begin
            s = get(sel, i);
            case (f)
                F_UND:   if (s.und) c++;
                F_RDY:   if (s.rdy) c++;
                F_STB:   if (s.stb) c++;
                default: if (s.xf) c++;
            endcase
        end
        return c;
    endfunction

    task automatic start_cap();
        tr_a.delete();
        tr_b.delete();
        cap = 1'b1;
    endtask

    task automatic push(input bit sel, input logic [7:0] d, input logic l, output bit ok);
        ok = 1'b0;
        if (sel) begin b_valid = 1'b1; b_data = d; b_last = l; end
        else     begin s_valid = 1'b1; s_data = d; s_last = l; end
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = sel ? b_ready : s_ready;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input bit sel, input byteq_t bytes, input bit with_last, output bit ok);
        bit o;
        ok = 1'b1;
        foreach (bytes[k]) begin
            push(sel, bytes[k], with_last && (k == bytes.size() - 1), o);
            ok &= o;
        end
    endtask

    task automatic drop(input bit sel);
        if (sel) begin b_valid = 1'b0; b_last = 1'b0; end
        else     begin s_valid = 1'b0; s_last = 1'b0; end
    endtask

    task automatic wait_idle(input bit sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((sel ? b_en : mod_en) == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
        b_valid = 1'b1; b_data = 8'h01; b_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({s_ready, bit_out, mod_en, sym_strobe, frame_active, underrun} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b want 000000", {s_ready, bit_out, mod_en, sym_strobe, frame_active, underrun});
            end
        end
        drop(0);
        drop(1);
        rst = 1'b0;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", s_ready); end
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", s_ready); end
        checks++;
        if (b_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release_b: got %b want 1", b_ready); end
        checks++;
        if (mod_en !== 1'b0) begin errors++; $display("FAIL no_xfer_in_reset: mod_en got %b want 0", mod_en); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        byteq_t f;
        bitq_t  w;
        bit     ok1, ok2;
        int     st, ln;
        smp_t   s;
        f.push_back(8'hC5);
        start_cap();
        push_frame(0, f, 1'b1, ok1);
        drop(0);
        wait_idle(0, 1000, ok2);
        cap = 1'b0;
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL single_timeout: got %0d%0d want 11", ok1, ok2); end
        st = run_start(0, 0);
        ln = run_len(0, st);
        w  = model_wave(f, SPS, PL, PRE);
        s  = get(0, st - 1);
        checks++;
        if (s.xf !== 1'b1) begin errors++; $display("FAIL single_latency: start %0d got xf %b want 1", st, s.xf); end
        checks++;
        if (ln !== 480) begin errors++; $display("FAIL single_length: got %0d want 480", ln); end
        checks++;
        if (wave_errs(0, st, w, SPS) !== 0) begin errors++; $display("FAIL single_wave: got %0d bad clocks want 0", wave_errs(0, st, w, SPS)); end
        checks++;
        if (count_f(0, st, ln, F_RDY) !== 0) begin errors++; $display("FAIL single_ready_blocked: got %0d want 0", count_f(0, st, ln, F_RDY)); end
        checks++;
        if (count_f(0, 0, tr_size(0), F_UND) !== 0) begin errors++; $display("FAIL single_underrun: got %0d want 0", count_f(0, 0, tr_size(0), F_UND)); end
        s = get(0, st + ln);
        checks++;
        if ({s.bo, s.rdy} !== 2'b00) begin errors++; $display("FAIL single_end: bit/ready got %b want 00", {s.bo, s.rdy}); end
        s = get(0, st + ln + 1);
        checks++;
        if (s.rdy !== 1'b1) begin errors++; $display("FAIL single_ready_return: got %b want 1", s.rdy); end
    endtask

    task automatic test_back_to_back();
        byteq_t f;
        bitq_t  w;
        bit     ok1, ok2;
        int     st, ln;
        f.push_back(8'hFF);
        f.push_back(8'h00);
        f.push_back(8'h81);
        start_cap();
        push_frame(0, f, 1'b1, ok1);
        drop(0);
        wait_idle(0, 1500, ok2);
        cap = 1'b0;
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL b2b_timeout: got %0d%0d want 11", ok1, ok2); end
        st = run_start(0, 0);
        ln = run_len(0, st);
        w  = model_wave(f, SPS, PL, PRE);
        checks++;
        if (ln !== 800) begin errors++; $display("FAIL b2b_length: got %0d want 800", ln); end
        checks++;
        if (wave_errs(0, st, w, SPS) !== 0) begin errors++; $display("FAIL b2b_wave: got %0d bad clocks want 0", wave_errs(0, st, w, SPS)); end
        checks++;
        if (count_f(0, st, ln, F_STB) !== 40) begin errors++; $display("FAIL b2b_strobes: got %0d want 40", count_f(0, st, ln, F_STB)); end
        checks++;
        if (count_f(0, 0, tr_size(0), F_UND) !== 0) begin errors++; $display("FAIL b2b_underrun: got %0d want 0", count_f(0, 0, tr_size(0), F_UND)); end
        checks++;
        if (count_f(0, 0, tr_size(0), F_XF) !== 3) begin errors++; $display("FAIL b2b_transfers: got %0d want 3", count_f(0, 0, tr_size(0), F_XF)); end
    endtask

    task automatic test_underrun();
        byteq_t f;
        bitq_t  w;
        bit     ok1, ok2;
        int     st, ln;
        smp_t   s;
        f.push_back(8'hAA);
        start_cap();
        push_frame(0, f, 1'b0, ok1);
        drop(0);
        wait_idle(0, 1000, ok2);
        cap = 1'b0;
        checks++;
        if (!(ok1 && ok2)) begin errors++; $display("FAIL underrun_timeout: got %0d%0d want 11", ok1, ok2); end
        st = run_start(0, 0);
        ln = run_len(0, st);
        w  = model_wave(f, SPS, PL, PRE);
        checks++;
        if (ln !== 480) begin errors++; $display("FAIL underrun_length: got %0d want 480", ln); end
        checks++;
        if (wave_errs(0, st, w, SPS) !== 0) begin errors++; $display("FAIL underrun_wave: got %0d bad clocks want 0", wave_errs(0, st, w, SPS)); end
        checks++;
        if (count_f(0, 0, tr_size(0), F_UND) !== 1) begin errors++; $display("FAIL underrun_pulses: got %0d want 1", count_f(0, 0, tr_size(0), F_UND)); end
        s = get(0, st + ln);
        checks++;
        if ({s.und, s.en} !== 2'b10) begin errors++; $display("FAIL underrun_align: und/en got %b want 10", {s.und, s.en}); end
    endtask

    task automatic test_mid_reset();
        byteq_t f;
        bitq_t  w;
        bit     ok1, ok2;
        int     st, ln;
        f.push_back(8'hC5);
        push_frame(0, f, 1'b1, ok1);
        drop(0);
        repeat (99) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({s_ready, bit_out, mod_en, sym_strobe, frame_active, underrun} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async: got %b want 000000", {s_ready, bit_out, mod_en, sym_strobe, frame_active, underrun});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({underrun, mod_en} !== 2'b00) begin errors++; $display("FAIL midreset_hold: und/en got %b want 00", {underrun, mod_en}); end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        f.delete();
        f.push_back(8'($urandom));
        start_cap();
        push_frame(0, f, 1'b1, ok1);
        drop(0);
        wait_idle(0, 1000, ok2);
        cap = 1'b0;
        st = run_start(0, 0);
        ln = run_len(0, st);
        w  = model_wave(f, SPS, PL, PRE);
        checks++;
        if (!(ok1 && ok2) || ln !== 480) begin errors++; $display("FAIL midreset_refrane: ok %0d%0d length %0d want 480", ok1, ok2, ln); end
        checks++;
        if (wave_errs(0, st, w, SPS) !== 0) begin errors++; $display("FAIL midreset_wave: byte %h got %0d bad clocks want 0", f[0], wave_errs(0, st, w, SPS)); end
        checks++;
        if (count_f(0, 0, tr_size(0), F_UND) !== 0) begin errors++; $display("FAIL midreset_underrun: got %0d want 0", count_f(0, 0, tr_size(0), F_UND)); end
    endtask

    task automatic test_small_config();
        byteq_t     f;
        bitq_t      w;
        bit         ok1, ok2;
        int         st, ln;
        smp_t       s;
        logic [11:0] pat;
        f.push_back(8'h01);
        start_cap();
        push_frame(1, f, 1'b1, ok1);
        drop(1);
        wait_idle(1, 200, ok2);
        cap = 1'b0;
        st = run_start(1, 0);
        ln = run_len(1, st);
        checks++;
        if (!(ok1 && ok2) || ln !== 24) begin errors++; $display("FAIL small_length: ok %0d%0d got %0d want 24", ok1, ok2, ln); end
        for (int i = 0; i < 12; i++) begin
            s = get(1, st + 2 * i);
            pat[11 - i] = s.bo;
        end
        checks++;
        if (pat !== 12'b1101_0000_0001) begin errors++; $display("FAIL small_pattern: got %b want 110100000001", pat); end
        w = model_wave(f, SPS_B, PL_B, PRE_B);
        checks++;
        if (wave_errs(1, st, w, SPS_B) !== 0) begin errors++; $display("FAIL small_wave: got %0d bad clocks want 0", wave_errs(1, st, w, SPS_B)); end
        for (int n = 0; n < 3; n++) begin
            f.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) f.push_back(8'($urandom));
            start_cap();
            push_frame(1, f, 1'b1, ok1);
            drop(1);
            wait_idle(1, 400, ok2);
            cap = 1'b0;
            st = run_start(1, 0);
            ln = run_len(1, st);
            w  = model_wave(f, SPS_B, PL_B, PRE_B);
            checks++;
            if (!(ok1 && ok2) || ln !== w.size() || wave_errs(1, st, w, SPS_B) !== 0) begin
                errors++;
                $display("FAIL small_random%0d: len %0d want %0d, bad clocks %0d want 0", n, ln, w.size(), wave_errs(1, st, w, SPS_B));
            end
        end
    endtask

    task automatic test_random_frames();
        byteq_t frames[3];
        bitq_t  w;
        bit     ok1, ok2, ok_all;
        int     st, ln;
        smp_t   s;
        ok_all = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) frames[f].push_back(8'($urandom));
        end
        start_cap();
        for (int f = 0; f < 3; f++) begin
            push_frame(0, frames[f], 1'b1, ok1);
            ok_all &= ok1;
        end
        drop(0);
        wait_idle(0, 3000, ok2);
        cap = 1'b0;
        checks++;
        if (!(ok_all && ok2)) begin errors++; $display("FAIL random_timeout: got %0d%0d want 11", ok_all, ok2); end
        for (int f = 0; f < 3; f++) begin
            st = run_start(0, f);
            ln = run_len(0, st);
            w  = model_wave(frames[f], SPS, PL, PRE);
            s  = get(0, st - 1);
            checks++;
            if (ln !== w.size() || s.xf !== 1'b1) begin
                errors++;
                $display("FAIL random_frame%0d_len: got %0d xf %b want %0d xf 1", f, ln, s.xf, w.size());
            end
            checks++;
            if (wave_errs(0, st, w, SPS) !== 0) begin errors++; $display("FAIL random_frame%0d_wave: got %0d bad clocks want 0", f, wave_errs(0, st, w, SPS)); end
        end
        checks++;
        if (run_start(0, 3) !== -1) begin errors++; $display("FAIL random_frame_count: extra frame at %0d want none", run_start(0, 3)); end
        checks++;
        if (count_f(0, 0, tr_size(0), F_UND) !== 0) begin errors++; $display("FAIL random_underrun: got %0d want 0", count_f(0, 0, tr_size(0), F_UND)); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_mid_reset();
        test_small_config();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
